// File: rtl/smg_pkg.sv
// Shared constants, types and helpers for the 7-segment data path.
package smg_pkg;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned MAX_VALUE = 9999;
  localparam int unsigned NUM_BITS  = 14;
  // Counter value on the final shift iteration (NUM_BITS - 1).
  localparam logic [3:0]  LAST_ITER = 4'd13;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // One display digit: BCD value plus rendering flags.
  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       dash;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{nib: 4'd0, blank: 1'b1, dash: 1'b0};
  localparam digit_t DIGIT_ZERO  = '{nib: 4'd0, blank: 1'b0, dash: 1'b0};

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/smg_seg_encode.sv
// Combinational BCD nibble to active-low 7-segment code, with dash/blank override.
module smg_seg_encode
  import smg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [7:0] seg_o
);

  // Dash wins over blank; out-of-range nibbles render blank.
  always_comb begin
    seg_o = SEG_BLANK;
    if (dash_i) begin
      seg_o = SEG_DASH;
    end else if (!blank_i) begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/smg_data_module.sv
// Binary-to-BCD display data stage: sequential double-dabble conversion, atomic
// display register update and scan-driven registered segment output.
module smg_data_module
  import smg_pkg::*;
#(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Load_Sig,
  input  logic [13:0] Number_Sig,
  input  logic [3:0]  Scan_Sig,
  output logic [7:0]  SMG_Data,
  output logic        Busy_Sig,
  output logic        Done_Sig
);

  // Blank in the configured output polarity.
  localparam logic [7:0] SegBlankOut = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [13:0]  bin_q, bin_d;
  logic [15:0]  bcd_q, bcd_d;
  logic         ovf_q, ovf_d;
  digit_t [3:0] disp_q, disp_d;
  logic [7:0]   seg_q, seg_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [15:0]  bcd_adj;
  digit_t [3:0] commit_digits;
  digit_t       sel_digit;
  logic [7:0]   seg_raw;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, DIGIT_ZERO};
      seg_q   <= SegBlankOut;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM next-state: loads only accepted in idle; fixed 14-iteration conversion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (Load_Sig) state_d = StShift;
      StShift:  if (cnt_q == LAST_ITER) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Commit-time digit formatting: dash on overflow, else leading-zero blanking.
  always_comb begin
    logic th_z, hu_z, te_z;
    th_z = (bcd_q[15:12] == 4'd0);
    hu_z = (bcd_q[11:8] == 4'd0);
    te_z = (bcd_q[7:4] == 4'd0);
    commit_digits[3] = '{nib: bcd_q[15:12], dash: ovf_q,
                         blank: BLANK_LEADING && !ovf_q && th_z};
    commit_digits[2] = '{nib: bcd_q[11:8], dash: ovf_q,
                         blank: BLANK_LEADING && !ovf_q && th_z && hu_z};
    commit_digits[1] = '{nib: bcd_q[7:4], dash: ovf_q,
                         blank: BLANK_LEADING && !ovf_q && th_z && hu_z && te_z};
    commit_digits[0] = '{nib: bcd_q[3:0], dash: ovf_q, blank: 1'b0};
  end

  // Conversion datapath: capture on load, adjust-then-shift, commit to display.
  always_comb begin
    bcd_adj = dabble_adjust(bcd_q);
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    unique case (state_q)
      StIdle: begin
        if (Load_Sig) begin
          bin_d = Number_Sig;
          ovf_d = (Number_Sig > 14'(MAX_VALUE));
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[14:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
      end
      StCommit: disp_d = commit_digits;
      default: ;
    endcase
  end

  // Output side: scan-selected digit, encoded, polarity applied, plus status flags.
  always_comb begin
    case (Scan_Sig)
      4'b1000: sel_digit = disp_q[3];
      4'b0100: sel_digit = disp_q[2];
      4'b0010: sel_digit = disp_q[1];
      4'b0001: sel_digit = disp_q[0];
      default: sel_digit = DIGIT_BLANK;
    endcase
    seg_d  = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;
    busy_d = (state_d != StIdle);
    done_d = (state_q == StCommit);
  end

  smg_seg_encode u_seg_encode (
    .nibble_i (sel_digit.nib),
    .blank_i  (sel_digit.blank),
    .dash_i   (sel_digit.dash),
    .seg_o    (seg_raw)
  );

  assign SMG_Data = seg_q;
  assign Busy_Sig = busy_q;
  assign Done_Sig = done_q;

endmodule

// File: doc/smg_data_module.md
# smg_data_module

Downstream partner of the digit scan stage in the 7-segment display path. Accepts a binary value (0–9999) on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Holds the result in a display register and, each time the scan stage's one-hot `Scan_Sig` selects a digit, drives that digit's registered segment pattern. Updates are atomic: the display never shows a half-converted value.

## Interface
Parameters:
- `BLANK_LEADING`, 1, 1 = leading zeros in thousands/hundreds/tens blanked; units digit is never blanked.
- `SEG_ACTIVE_LOW`, 1, 1 = common-anode (segment on = 0); 0 = every `SMG_Data` bit inverted.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RSTn`  in  1  reset, synchronous, active-low.
- `Load_Sig`  in  1  single-cycle request to convert `Number_Sig`.
- `Number_Sig`  in  14  binary value; sampled only on an accepted load.
- `Scan_Sig`  in  4  one-hot digit select from the scan stage: `1000` thousands, `0100` hundreds, `0010` tens, `0001` units.
- `SMG_Data`  out  8  segment pattern `{dp,g,f,e,d,c,b,a}`, registered.
- `Busy_Sig`  out  1  conversion in progress; loads are ignored while high.
- `Done_Sig`  out  1  one-cycle pulse when the display register is updated.

## Operation
- FSM states:
  - IDLE: on `Load_Sig`=1, capture `Number_Sig`, clear the BCD shift register and the 4-bit iteration counter, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, taking in the next binary MSB. After 14 iterations (counter == 13), go to COMMIT.
  - COMMIT: copy the BCD into the display register, pulse `Done_Sig`, return to IDLE.
- `Busy_Sig` = (state != IDLE), registered.
- Overflow: if the captured value is >9999, COMMIT writes the dash code to all four digits. The conversion still runs its full length, so latency is fixed.
- `Load_Sig` in SHIFT or COMMIT is dropped. It is not queued.
- Active-low segment codes:
  - digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90
  - dash: BF; blank: FF
  - dp is always off.
- Blanking with `BLANK_LEADING`=1: the thousands digit is blank if 0; the hundreds digit is blank if it and the thousands digit are both 0; the tens digit is blank if it and all higher digits are 0. Dash codes are never blanked.
- Output mux:
  - `SMG_Data` is registered from the display digit selected by `Scan_Sig`.
  - `Scan_Sig`=0000 or any non-one-hot value gives blank (FF). This covers the scan stage's post-reset state.
- Reset (sync, `RSTn`=0 at an edge):
  - state = IDLE; counter and shift register cleared.
  - Display register = all-blank, with the units digit holding 0 (code C0 once selected).
  - `SMG_Data`=FF, `Busy_Sig`=0, `Done_Sig`=0.
  - Reset mid-conversion aborts it; the display register is restored to its reset content.

## Timing
- Load accepted at edge k: `Busy_Sig` is high after edges k through k+14 (15 cycles).
- Shift iterations occur at edges k+1 … k+14. COMMIT executes at edge k+15.
- `Done_Sig` is high for exactly the one cycle after edge k+15. `Busy_Sig` is low in that same cycle.
- The earliest next accepted load is at edge k+16.
- `SMG_Data` reflects `Scan_Sig` and the display register one cycle late. A `Scan_Sig` change seen at edge n appears after edge n.
- A commit while a digit is selected updates `SMG_Data` one cycle after the commit.
- `Scan_Sig` comes from the 1 ms tick domain but is assumed synchronous to `CLK` (same clock, enable-based); no synchronizer is used.

## Structure
- Shared package `smg_pkg`:
  - segment code constants (SEG_0 … SEG_9, SEG_DASH, SEG_BLANK)
  - FSM state encoding (IDLE, SHIFT, COMMIT)
  - MAX_VALUE = 9999
- One sub-module, `smg_seg_encode`: combinational BCD nibble + blank flag + dash flag → 8-bit active-low code, instantiated once after the output mux. Polarity inversion is applied in the parent.

## Test plan
- Reset, then `Load_Sig` with `Number_Sig`=1234, then `Scan_Sig` stepped 1000/0100/0010/0001 → `Busy_Sig` for 15 cycles, `Done_Sig` after 16; `SMG_Data` = F9, A4, B0, 99.
- `Number_Sig`=7, `BLANK_LEADING`=1 → FF, FF, FF, F8. Repeat with 1005 → F9, C0, C0, 92 (internal zeros shown).
- `Number_Sig`=10000 → BF on all four digits. Then 9999 → 90 ×4.
- Load 1234; a second load of 5678 at cycle 5 is ignored → display 1234 and a single `Done_Sig`. A load at exactly k+16 is accepted.
- `RSTn` low at cycle 8 of a conversion of 4321 → `Busy_Sig`=0 next cycle, no `Done_Sig`; units digit = C0, others FF.
- `Scan_Sig`=0000, then 1100 → `SMG_Data`=FF. `SEG_ACTIVE_LOW`=0 with 8 on units → 7F.
